// File: rtl/div32u16_seq.sv
// div32u16_seq
// Sequential restoring divider. It divides a 2W-bit unsigned dividend by a
// W-bit unsigned divisor and resolves one quotient bit per RUN cycle, MSB first.
// A zero divisor and a quotient that cannot fit in W bits are reported in
// one cycle through the dbz and ovf flags. In both cases Q and R read as all ones.
//
// Ports
//   clk        : clock. All state changes on the rising edge.
//   rst        : synchronous active-high reset. It aborts any operation in flight.
//   A          : 2W-bit unsigned dividend.
//   B          : W-bit unsigned divisor.
//   in_valid   : A and B are present.
//   in_ready   : the block accepts operands. High only in IDLE.
//   out_valid  : Q, R, dbz and ovf are valid. High only in DONE.
//   out_ready  : the consumer takes the result.
//   Q, R       : quotient and remainder.
//   dbz, ovf   : divide-by-zero and quotient-overflow flags.
//
// Configuration macro DIV_APPROX_EN
//   Defined   : RUN lasts W/4 cycles. Only the top W/4 quotient bits are
//               produced. The lower bits of Q and all of R read as zero.
//   Undefined : exact divider. RUN lasts W cycles.
module div32u16_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*W-1:0]   A,
    input  logic [W-1:0]     B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     Q,
    output logic [W-1:0]     R,
    output logic             dbz,
    output logic             ovf
);

`ifdef DIV_APPROX_EN
    localparam int ITER = W / 4;
    localparam int QB   = W / 4;
`else
    localparam int ITER = W;
`endif
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      rem_q, rem_d;   // partial remainder, one guard bit
    logic [W-1:0]    dvd_q, dvd_d;   // low dividend bits out, quotient bits in
    logic [W-1:0]    div_q, div_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [W+1:0]    trial;
    logic            take;
    logic [W:0]      step_rem;
    logic [W-1:0]    step_dvd;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The quotient bit is the "fits" result.
    always_comb begin
        trial    = {rem_q, dvd_q[W-1]};
        take     = (trial >= {2'b00, div_q});
        step_rem = take ? (W+1)'(trial - {2'b00, div_q}) : (W+1)'(trial);
        step_dvd = {dvd_q[W-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (B == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        q_d     = '1;
                        r_d     = '1;
                    end else if (A[2*W-1:W] >= B) begin
                        state_d = DONE;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '1;
                    end else begin
                        // The high half is already below B, so it is the
                        // starting partial remainder.
                        state_d = RUN;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        rem_d   = {1'b0, A[2*W-1:W]};
                        dvd_d   = A[W-1:0];
                        div_d   = B;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
`ifdef DIV_APPROX_EN
                    q_d = {dvd_q[QB-2:0], take, {(W-QB){1'b0}}};
                    r_d = '0;
`else
                    q_d = step_dvd;
                    r_d = step_rem[W-1:0];
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = q_q;
    assign R         = r_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/div32u16_seq.md
DIV32U16_SEQ -- requirements
Module: div32u16_seq

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning divisor/quotient/remainder width; the dividend is 2W bits wide.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port A  input  2W  unsigned dividend (product-domain operand).
REQ-005 The block SHALL have port B  input  W  unsigned divisor.
REQ-006 The block SHALL have port in_valid  input  1  operands A/B present.
REQ-007 The block SHALL have port in_ready  output  1  block accepts operands.
REQ-008 The block SHALL have port out_valid  output  1  result Q/R/flags valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-010 The block SHALL have port Q  output  W  quotient.
REQ-011 The block SHALL have port R  output  W  remainder.
REQ-012 The block SHALL have port dbz  output  1  divide-by-zero flag.
REQ-013 The block SHALL have port ovf  output  1  quotient-overflow flag (A[2W-1:W] >= B, B != 0).

Function
REQ-014 The block SHALL implement a restoring divider with states IDLE, RUN, DONE, resolving one quotient bit per RUN cycle, MSB first.
REQ-015 The block SHALL have in_ready = 1 only in IDLE; accept occurs on the cycle t where in_valid & in_ready, and it registers A and B then.
REQ-016 On accept with B == 0, the block SHALL go to DONE with dbz=1, ovf=0, Q={W{1}}, R={W{1}}; out_valid at t+1.
REQ-017 On accept with B != 0 and A[2W-1:W] >= B, the block SHALL go to DONE with ovf=1, dbz=0, Q={W{1}}, R={W{1}}; out_valid at t+1.
REQ-018 Otherwise the block SHALL go to RUN for exactly W cycles, then to DONE; out_valid at t+W+1, with Q = floor(A/B), R = A mod B, and flags 0.
REQ-019 The partial remainder SHALL be held in W+1 bits so that the trial subtraction never wraps.
REQ-020 In DONE, Q/R/dbz/ovf SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 When out_valid & out_ready, the block SHALL return to IDLE next cycle; in_ready=1 that cycle; no new accept occurs in the handshake cycle itself.
REQ-022 in_valid SHALL be ignored outside IDLE, and A/B changes during RUN/DONE SHALL have no effect on the result.
REQ-023 Q/R/dbz/ovf SHALL be don't-care while out_valid=0; the bench checks them only under out_valid.

Reset
REQ-024 rst=1 at any clock edge SHALL force IDLE, out_valid=0, Q=0, R=0, dbz=0, ovf=0, and internal counter/remainder to 0; in_ready=1 from the following cycle.
REQ-025 rst asserted during RUN or DONE SHALL abort the operation with no result ever presented.
REQ-026 rst SHALL have priority over a simultaneous in_valid; no accept occurs in a reset cycle.

Configuration
REQ-027 When macro DIV_APPROX_EN is defined, RUN SHALL last W/4 cycles and produce only Q[W-1:3W/4] exactly, with Q[3W/4-1:0]=0, R=0, and out_valid at t+W/4+1; dbz/ovf behaviour is unchanged.
REQ-028 When DIV_APPROX_EN is undefined, the block SHALL be the exact divider of REQ-018, with no approximation logic present.

Verification
REQ-029 A=32'd1000, B=16'd7 accepted at t -> out_valid at t+17, Q=16'd142, R=16'd6, dbz=0, ovf=0.
REQ-030 A=32'hFFFE0001, B=16'hFFFF -> Q=16'hFFFF, R=16'h0000, ovf=0 at t+17; A=32'h12345678, B=16'h2000 -> Q=16'h91A2, R=16'h1678 (with DIV_APPROX_EN: Q=16'h9000, R=0 at t+5).
REQ-031 B=16'h0000, A=32'h00001234 -> out_valid at t+1, dbz=1, ovf=0, Q=16'hFFFF, R=16'hFFFF; A=32'h00070000, B=16'd7 -> ovf=1, dbz=0 at t+1.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid -> Q/R/flags unchanged and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, next accept one cycle later.
REQ-033 rst pulsed at RUN cycle 8 of 1000/7 -> out_valid=0 and in_ready=1 the cycle after rst deasserts; a new 1000/7 then completes correctly at t+17.
